alu_issue_stage: RTL and testbench

Registered issue stage between instruction decode and the `alu` execute block. It accepts one decoded instruction per cycle over a valid/ready handshake and translates `ALUOp`/`Funct3`/`Funct7` into the 4-bit ALU `Operation` code. It selects and conditions `SrcA`/`SrcB`, and presents them to the ALU through a two-entry skid buffer. The buffer sustains full throughput while keeping `ready_out` registered.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_op_decode.sv | 45 ++++
 rtl/alu_issue_stage.sv | 131 +++++++++++++
 tb/tb_alu_issue_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes, ALUOp classes and issue-stage states
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_SLL = 4'b0100,
    OP_SRL = 4'b0101,
    OP_XOR = 4'b0110,
    OP_SRA = 4'b0111,
    OP_BEQ = 4'b1000,
    OP_BNE = 4'b1001,
    OP_BLT = 4'b1010,
    OP_BGE = 4'b1011,
    OP_SLT = 4'b1100,
    OP_LUI = 4'b1111
  } alu_op_t;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ARITH  = 2'b10;
  localparam logic [1:0] ALUOP_UPPER  = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } issue_state_t;

  function automatic logic is_shift(alu_op_t op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - ALUOp/Funct3/Funct7 to 4-bit ALU operation code
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       alu_src_i,
  output alu_op_t    op_o
);

  logic unused_funct7;
  assign unused_funct7 = ^{funct7_i[6], funct7_i[4:0]};

  always_comb begin
    op_o = OP_ADD;
    case (alu_op_i)
      ALUOP_MEM:   op_o = OP_ADD;
      ALUOP_UPPER: op_o = OP_LUI;
      ALUOP_BRANCH: begin
        case (funct3_i)
          3'b000:          op_o = OP_BEQ;
          3'b001:          op_o = OP_BNE;
          3'b100, 3'b110:  op_o = OP_BLT;
          3'b101, 3'b111:  op_o = OP_BGE;
          default:         op_o = OP_AND;
        endcase
      end
      default: begin
        case (funct3_i)
          // I-type immediates can carry bit 30 set, so SUB needs the register form
          3'b000:  op_o = (funct7_i[5] && !alu_src_i) ? OP_SUB : OP_ADD;
          3'b001:  op_o = OP_SLL;
          3'b010,
          3'b011:  op_o = OP_SLT;
          3'b100:  op_o = OP_XOR;
          3'b101:  op_o = funct7_i[5] ? OP_SRA : OP_SRL;
          3'b110:  op_o = OP_OR;
          default: op_o = OP_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - registered ALU issue stage with two-entry skid buffer
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  output logic                     ready_out,
  input  logic [1:0]               ALUOp,
  input  logic [2:0]               Funct3,
  input  logic [6:0]               Funct7,
  input  logic                     ALUSrc,
  input  logic [DATA_WIDTH-1:0]    RD1,
  input  logic [DATA_WIDTH-1:0]    RD2,
  input  logic [DATA_WIDTH-1:0]    Imm,
  input  logic                     flush,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation
);

  alu_op_t               in_op;
  logic [DATA_WIDTH-1:0] in_b_raw;
  logic [DATA_WIDTH-1:0] in_b;

  alu_op_decode u_decode (
    .alu_op_i  (ALUOp),
    .funct3_i  (Funct3),
    .funct7_i  (Funct7),
    .alu_src_i (ALUSrc),
    .op_o      (in_op)
  );

  assign in_b_raw = ALUSrc ? Imm : RD2;
  // shamt only: drops the funct7 bits SRAI carries in its immediate
  assign in_b = is_shift(in_op) ? {{(DATA_WIDTH-5){1'b0}}, in_b_raw[4:0]} : in_b_raw;

  issue_state_t          state_q, state_d;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] main_a_q, main_b_q, skid_a_q, skid_b_q;
  alu_op_t               main_op_q, skid_op_q;
  logic                  accept, consume;
  logic                  load_main_in, load_main_skid, load_skid;

  assign accept  = valid_in & ready_q;
  assign consume = (state_q != ST_EMPTY) & ready_in;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d      = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_d   = ST_TWO;
            load_skid = 1'b1;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (consume) begin
            state_d        = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != ST_TWO);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_a_q  <= '0;
      main_b_q  <= '0;
      main_op_q <= OP_AND;
      skid_a_q  <= '0;
      skid_b_q  <= '0;
      skid_op_q <= OP_AND;
    end else begin
      if (load_main_in) begin
        main_a_q  <= RD1;
        main_b_q  <= in_b;
        main_op_q <= in_op;
      end else if (load_main_skid) begin
        main_a_q  <= skid_a_q;
        main_b_q  <= skid_b_q;
        main_op_q <= skid_op_q;
      end
      if (load_skid) begin
        skid_a_q  <= RD1;
        skid_b_q  <= in_b;
        skid_op_q <= in_op;
      end
    end
  end

  assign ready_out = ready_q;
  assign valid_out = (state_q != ST_EMPTY);
  assign SrcA      = main_a_q;
  assign SrcB      = main_b_q;
  assign Operation = OPCODE_LENGTH'(main_op_q);

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - decode table plus scoreboard checks for alu_issue_stage
module tb_alu_issue_stage;

  typedef struct {
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        src;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [3:0]  op;
    logic [31:0] b;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } exp_t;

  localparam int NV = 22;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        ready_out;
  logic [1:0]  ALUOp;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic        ALUSrc;
  logic [31:0] RD1, RD2, Imm;
  logic        flush;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] SrcA, SrcB;
  logic [3:0]  Operation;

  int   passed = 0;
  int   total = 0;
  int   cyc = 0;
  int   cons_cnt = 0;
  exp_t cur_exp;
  exp_t sb[$];
  vec_t vecs[NV];

  alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .ALUOp     (ALUOp),
    .Funct3    (Funct3),
    .Funct7    (Funct7),
    .ALUSrc    (ALUSrc),
    .RD1       (RD1),
    .RD2       (RD2),
    .Imm       (Imm),
    .flush     (flush),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Operation (Operation)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) $display("FAIL %s actual=%h required=%h", nm, act, req);
    else passed++;
  endtask

  function automatic vec_t mk(input logic [1:0] aluop, input logic [2:0] f3, input logic [6:0] f7,
                              input logic src, input logic [31:0] rd2, input logic [31:0] imm,
                              input logic [3:0] op, input logic [31:0] b);
    vec_t v;
    v.aluop = aluop; v.f3 = f3; v.f7 = f7; v.src = src;
    v.rd1 = 32'h0; v.rd2 = rd2; v.imm = imm; v.op = op; v.b = b;
    return v;
  endfunction

  // Scoreboard: beats pushed on handshake, popped when the ALU side consumes.
  always @(negedge clk) begin
    exp_t e;
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (valid_out && ready_in) begin
        cons_cnt++;
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_beat actual=op %h a %h required=no beat", Operation, SrcA);
        end else begin
          e = sb.pop_front();
          chk("sb_srca", SrcA, e.a);
          chk("sb_srcb", SrcB, e.b);
          chk("sb_op", 32'(Operation), 32'(e.op));
        end
      end
      if (valid_in && ready_out) sb.push_back(cur_exp);
    end
  end

  task automatic drive(input vec_t v);
    ALUOp = v.aluop; Funct3 = v.f3; Funct7 = v.f7; ALUSrc = v.src;
    RD1 = v.rd1; RD2 = v.rd2; Imm = v.imm;
    cur_exp.a = v.rd1; cur_exp.b = v.b; cur_exp.op = v.op;
    valid_in = 1'b1;
  endtask

  task automatic send(input vec_t v);
    int   n;
    logic acc;
    drive(v);
    n = 0;
    acc = 1'b0;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = ready_out;
      @(posedge clk);
      #1;
      n++;
    end
    valid_in = 1'b0;
    if (!acc) begin
      total++;
      $display("FAIL send_timeout actual=not accepted required=accepted within 40 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, k0;
    reset = 1'b1; valid_in = 1'b0; flush = 1'b0; ready_in = 1'b0;
    ALUOp = 2'b00; Funct3 = 3'b000; Funct7 = 7'h00; ALUSrc = 1'b0;
    RD1 = '0; RD2 = '0; Imm = '0;
    cur_exp.a = '0; cur_exp.b = '0; cur_exp.op = '0;

    vecs[0]  = mk(2'b10, 3'b000, 7'h20, 1'b0, 32'h3,        32'h0,        4'b0011, 32'h3);
    vecs[1]  = mk(2'b10, 3'b000, 7'h20, 1'b1, 32'h3,        32'h405,      4'b0010, 32'h405);
    vecs[2]  = mk(2'b10, 3'b000, 7'h00, 1'b0, 32'h1234,     32'h0,        4'b0010, 32'h1234);
    vecs[3]  = mk(2'b10, 3'b101, 7'h20, 1'b1, 32'h0,        32'h405,      4'b0111, 32'h5);
    vecs[4]  = mk(2'b10, 3'b101, 7'h00, 1'b0, 32'hFFFFFF23, 32'h0,        4'b0101, 32'h3);
    vecs[5]  = mk(2'b10, 3'b001, 7'h00, 1'b0, 32'h47,       32'h0,        4'b0100, 32'h7);
    vecs[6]  = mk(2'b10, 3'b010, 7'h00, 1'b0, 32'hFFFFFF23, 32'h0,        4'b1100, 32'hFFFFFF23);
    vecs[7]  = mk(2'b10, 3'b011, 7'h00, 1'b1, 32'h0,        32'hFFFFF800, 4'b1100, 32'hFFFFF800);
    vecs[8]  = mk(2'b10, 3'b100, 7'h00, 1'b0, 32'h55,       32'h0,        4'b0110, 32'h55);
    vecs[9]  = mk(2'b10, 3'b110, 7'h20, 1'b0, 32'h66,       32'h0,        4'b0001, 32'h66);
    vecs[10] = mk(2'b10, 3'b111, 7'h00, 1'b0, 32'h77,       32'h0,        4'b0000, 32'h77);
    vecs[11] = mk(2'b01, 3'b000, 7'h00, 1'b0, 32'h11111111, 32'h0,        4'b1000, 32'h11111111);
    vecs[12] = mk(2'b01, 3'b001, 7'h00, 1'b0, 32'h22222222, 32'h0,        4'b1001, 32'h22222222);
    vecs[13] = mk(2'b01, 3'b010, 7'h00, 1'b0, 32'h33333333, 32'h0,        4'b0000, 32'h33333333);
    vecs[14] = mk(2'b01, 3'b011, 7'h00, 1'b0, 32'h44444444, 32'h0,        4'b0000, 32'h44444444);
    vecs[15] = mk(2'b01, 3'b100, 7'h00, 1'b0, 32'h55555555, 32'h0,        4'b1010, 32'h55555555);
    vecs[16] = mk(2'b01, 3'b101, 7'h00, 1'b0, 32'h66666666, 32'h0,        4'b1011, 32'h66666666);
    vecs[17] = mk(2'b01, 3'b110, 7'h00, 1'b0, 32'h77777777, 32'h0,        4'b1010, 32'h77777777);
    vecs[18] = mk(2'b01, 3'b111, 7'h00, 1'b0, 32'h88888888, 32'h0,        4'b1011, 32'h88888888);
    vecs[19] = mk(2'b11, 3'b000, 7'h00, 1'b1, 32'h0,        32'h12345000, 4'b1111, 32'h12345000);
    vecs[20] = mk(2'b00, 3'b010, 7'h00, 1'b1, 32'h0,        32'hFFFFFFFC, 4'b0010, 32'hFFFFFFFC);
    vecs[21] = mk(2'b10, 3'b001, 7'h20, 1'b1, 32'h0,        32'h43F,      4'b0100, 32'h1F);
    for (int i = 0; i < NV; i++) vecs[i].rd1 = 32'h100 + 32'(i);
    vecs[0].rd1 = 32'h7;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_out", 32'(valid_out), 32'h0);
    chk("rst_ready_out", 32'(ready_out), 32'h1);
    chk("rst_operation", 32'(Operation), 32'h0);
    chk("rst_srca", SrcA, 32'h0);
    chk("rst_srcb", SrcB, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Table: first beat checked for one-edge latency, rest streamed back-to-back.
    ready_in = 1'b1;
    send(vecs[0]);
    chk("lat_valid_out", 32'(valid_out), 32'h1);
    chk("lat_operation", 32'(Operation), 32'h3);
    chk("lat_srca", SrcA, 32'h7);
    chk("lat_srcb", SrcB, 32'h3);
    c0 = cyc;
    for (int i = 1; i < NV; i++) send(vecs[i]);
    chk("throughput_cycles", 32'(cyc - c0), 32'(NV - 1));
    repeat (3) @(posedge clk);
    #1;
    chk("table_drained", 32'(sb.size()), 32'h0);

    // Backpressure: A, B fill both entries, C is held off until drain.
    ready_in = 1'b0;
    k0 = cons_cnt;
    send(vecs[3]);
    chk("bp_ready_after_a", 32'(ready_out), 32'h1);
    send(vecs[12]);
    chk("bp_ready_after_b", 32'(ready_out), 32'h0);
    chk("bp_hold_op", 32'(Operation), 32'(vecs[3].op));
    drive(vecs[19]);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_ready_held", 32'(ready_out), 32'h0);
    chk("bp_hold_srca", SrcA, vecs[3].rd1);
    chk("bp_hold_srcb", SrcB, vecs[3].b);
    ready_in = 1'b1;
    send(vecs[19]);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_consumed", 32'(cons_cnt - k0), 32'h3);
    chk("bp_drained", 32'(sb.size()), 32'h0);

    // Flush in TWO with a beat offered.
    ready_in = 1'b0;
    send(vecs[5]);
    send(vecs[6]);
    drive(vecs[7]);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    valid_in = 1'b0;
    chk("flush2_valid_out", 32'(valid_out), 32'h0);
    chk("flush2_ready_out", 32'(ready_out), 32'h1);

    // Flush in ONE where the offered beat would otherwise be accepted.
    send(vecs[8]);
    drive(vecs[9]);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    valid_in = 1'b0;
    chk("flush1_valid_out", 32'(valid_out), 32'h0);
    k0 = cons_cnt;
    ready_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("flush_no_output", 32'(cons_cnt - k0), 32'h0);
    chk("flush_valid_stays_low", 32'(valid_out), 32'h0);

    // Asynchronous reset between edges while in TWO.
    ready_in = 1'b0;
    send(vecs[15]);
    send(vecs[16]);
    chk("pre_rst_ready_out", 32'(ready_out), 32'h0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid_out", 32'(valid_out), 32'h0);
    chk("arst_ready_out", 32'(ready_out), 32'h1);
    chk("arst_srca", SrcA, 32'h0);
    chk("arst_srcb", SrcB, 32'h0);
    chk("arst_operation", 32'(Operation), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    ready_in = 1'b1;
    k0 = cons_cnt;
    send(vecs[21]);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_consumed", 32'(cons_cnt - k0), 32'h1);
    chk("final_drained", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
